// File: rtl/crc_serial_checker.sv
// Purpose : serial CRC checker; runs the LFSR over DATA_WIDTH payload bits, then compares CRC_WIDTH received CRC bits (all LSB first).
// Latency : done/crc_ok/crc_err update on the edge that samples the last CRC bit (visible the following cycle).
// Backpr. : none; in_valid=0 simply stalls the frame, with no timeout.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset; discards any frame in flight
//   in_bit   - serial frame bit
//   in_valid - in_bit is consumed on this edge
//   busy     - frame in progress (registered)
//   done     - one-cycle pulse when a frame completes
//   crc_ok   - last frame matched; held until the next frame starts
//   crc_err  - last frame mismatched; held until the next frame starts
module crc_serial_checker #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0] POLY       = 8'h44,
    parameter logic [CRC_WIDTH-1:0] SEED       = 8'hD8
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    output logic busy,
    output logic done,
    output logic crc_ok,
    output logic crc_err
);

    localparam int MAXW  = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
    localparam int CNT_W = $clog2(MAXW);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [CRC_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mis_q, mis_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ok_q, ok_d;
    logic                 err_q, err_d;
    logic                 mis_new;

    // Galois-style right-shifting LFSR step for one payload bit.
    function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] cur,
                                                       input logic                 d);
        logic                 fb;
        logic [CRC_WIDTH-1:0] nxt;
        fb = d ^ cur[0];
        for (int i = 0; i < CRC_WIDTH - 1; i++) begin
            nxt[i] = cur[i+1] ^ (POLY[i] & fb);
        end
        nxt[CRC_WIDTH-1] = fb;
        return nxt;
    endfunction

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        mis_new = mis_q | (in_bit ^ lfsr_q[0]);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // First bit always steps from SEED, never from the stale LFSR
                    // left behind by the previous frame's CHECK shifting.
                    lfsr_d = lfsr_step(SEED, in_bit);
                    mis_d  = 1'b0;
                    ok_d   = 1'b0;
                    err_d  = 1'b0;
                    if (DATA_WIDTH == 1) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid) begin
                    lfsr_d = lfsr_step(lfsr_q, in_bit);
                    if (cnt_q == DATA_LAST) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (in_valid) begin
                    // LFSR bit 0 always holds the next expected CRC bit.
                    mis_d  = mis_new;
                    lfsr_d = {1'b0, lfsr_q[CRC_WIDTH-1:1]};
                    if (cnt_q == CRC_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        err_d   = mis_new;
                        ok_d    = ~mis_new;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign crc_ok  = ok_q;
    assign crc_err = err_q;

endmodule
